// File: rtl/merge_arb.sv
`default_nettype none
// ============================================================================
// Module   : merge_arb
// Purpose  : Merges two four-phase handshake request channels onto one shared
//            four-phase output channel, one transaction at a time. Contention
//            is resolved round-robin (FAIR=1) or with channel 0 always winning
//            (FAIR=0).
// Ports    : clk, rst       - clock, synchronous active-high reset
//            r0_i / a0_i    - channel 0 request in / acknowledge out
//            r1_i / a1_i    - channel 1 request in / acknowledge out
//            r_o  / a_o     - shared channel request out / acknowledge in
//            gnt_o[1:0]     - one-hot current grant (00 when idle)
//            busy_o         - high whenever a transaction is in progress
// Options  : MERGE_ARB_SYNC_EN - when defined, every input passes through a
//            two-flop synchroniser instead of a single sample flop.
// Revision : 1.0 - initial release
// ============================================================================
module merge_arb #(
    parameter logic FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_i,
    output logic       a0_i,
    input  logic       r1_i,
    output logic       a1_i,
    output logic       r_o,
    input  logic       a_o,
    output logic [1:0] gnt_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ACKD = 2'd2,
        RTZ  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input sample stage: bit0 = r0_i, bit1 = r1_i, bit2 = a_o
    // ------------------------------------------------------------------
    logic [2:0] samp_q;

`ifdef MERGE_ARB_SYNC_EN
    logic [2:0] meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 3'b000;
            samp_q <= 3'b000;
        end else begin
            meta_q <= {a_o, r1_i, r0_i};
            samp_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= 3'b000;
        end else begin
            samp_q <= {a_o, r1_i, r0_i};
        end
    end
`endif

    logic s_r0;
    logic s_r1;
    logic s_a;

    assign s_r0 = samp_q[0];
    assign s_r1 = samp_q[1];
    assign s_a  = samp_q[2];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [1:0] gnt_q,   gnt_d;
    logic       prio_q,  prio_d;     // 0: channel 0 holds priority

    logic       s_rg;                // sampled request of the granted channel

    assign s_rg = gnt_q[0] ? s_r0 : s_r1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (s_r0 && s_r1) begin
                    state_d = FWD;
                    gnt_d   = (FAIR && prio_q) ? 2'b10 : 2'b01;
                end else if (s_r0) begin
                    state_d = FWD;
                    gnt_d   = 2'b01;
                end else if (s_r1) begin
                    state_d = FWD;
                    gnt_d   = 2'b10;
                end
            end
            // A granted request dropping early is deliberately not looked at
            // here; ACKD sees it low and moves straight on to RTZ.
            FWD: begin
                if (s_a) begin
                    state_d = ACKD;
                end
            end
            ACKD: begin
                if (!s_rg) begin
                    state_d = RTZ;
                end
            end
            RTZ: begin
                if (!s_a) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    prio_d  = ~prio_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers, decoded from the current state/grant registers so
    // every output is a clean flop output, one clock behind the FSM.
    // ------------------------------------------------------------------
    logic       r_out_q;
    logic       a0_out_q;
    logic       a1_out_q;
    logic [1:0] gnt_out_q;
    logic       busy_out_q;
    logic       w_ack_phase;

    assign w_ack_phase = (state_q == ACKD) || (state_q == RTZ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q    <= 1'b0;
            a0_out_q   <= 1'b0;
            a1_out_q   <= 1'b0;
            gnt_out_q  <= 2'b00;
            busy_out_q <= 1'b0;
        end else begin
            r_out_q    <= (state_q == FWD) || (state_q == ACKD);
            a0_out_q   <= w_ack_phase && gnt_q[0];
            a1_out_q   <= w_ack_phase && gnt_q[1];
            gnt_out_q  <= gnt_q;
            busy_out_q <= (state_q != IDLE);
        end
    end

    assign r_o    = r_out_q;
    assign a0_i   = a0_out_q;
    assign a1_i   = a1_out_q;
    assign gnt_o  = gnt_out_q;
    assign busy_o = busy_out_q;

endmodule
`default_nettype wire

// File: tb/tb_merge_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_merge_arb
// Purpose  : Self-checking bench for merge_arb. Drives two instances
//            (FAIR=1 as dut0, FAIR=0 as dut1) with directed handshakes and
//            checks response latencies, grant choice and output invariants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_merge_arb;

`ifdef MERGE_ARB_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int RSP = LAT + 2;   // edges from an input change to the response

    logic       clk = 1'b0;
    logic       rst;
    logic       r0   [2];
    logic       r1   [2];
    logic       ao   [2];
    logic       ro   [2];
    logic       a0   [2];
    logic       a1   [2];
    logic [1:0] gnt  [2];
    logic       busy [2];

    int         tests = 0;
    int         fails = 0;
    bit         chk_en = 1'b0;
    bit         mprio   [2];        // model: 1 = channel 1 holds priority
    logic [1:0] exp_gnt [2];        // model: grant of the current transaction

    always #5 clk = ~clk;

    merge_arb #(.FAIR(1'b1)) u_dut0 (
        .clk(clk), .rst(rst),
        .r0_i(r0[0]), .a0_i(a0[0]), .r1_i(r1[0]), .a1_i(a1[0]),
        .r_o(ro[0]), .a_o(ao[0]), .gnt_o(gnt[0]), .busy_o(busy[0])
    );

    merge_arb #(.FAIR(1'b0)) u_dut1 (
        .clk(clk), .rst(rst),
        .r0_i(r0[1]), .a0_i(a0[1]), .r1_i(r1[1]), .a1_i(a1[1]),
        .r_o(ro[1]), .a_o(ao[1]), .gnt_o(gnt[1]), .busy_o(busy[1])
    );

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    // Model of the arbitration rule: lone request wins; on contention the
    // FAIR instance follows the priority holder, the other picks channel 0.
    function automatic int winner(input int d, input logic q0, input logic q1);
        if (q0 && q1) begin
            if (d == 0 && mprio[d]) return 1;
            return 0;
        end
        return q0 ? 0 : 1;
    endfunction

    function automatic logic get_sig(input int d, input int which);
        case (which)
            0:       return ro[d];
            1:       return a0[d];
            2:       return a1[d];
            default: return busy[d];
        endcase
    endfunction

    // Counts edges until the chosen output reaches val (bounded).
    task automatic wait_sig(input int d, input int which, input logic val, output int n);
        n = 0;
        while (get_sig(d, which) !== val && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (get_sig(d, which) !== val)
            check("wait_timeout", d, {31'd0, get_sig(d, which)}, {31'd0, val});
    endtask

    // One full four-phase transaction for channel ch, requests already raised.
    task automatic serve(input int d, input int ch, input int lat_r);
        int n;
        exp_gnt[d] = (ch == 0) ? 2'b01 : 2'b10;
        wait_sig(d, 0, 1'b1, n);
        if (lat_r >= 0) check("req_to_ro", d, n, lat_r);
        check("gnt_fwd", d, {30'd0, gnt[d]}, {30'd0, exp_gnt[d]});
        ao[d] = 1'b1;
        wait_sig(d, 1 + ch, 1'b1, n);
        check("ao_to_ack", d, n, RSP);
        if (ch == 0) r0[d] = 1'b0; else r1[d] = 1'b0;
        wait_sig(d, 0, 1'b0, n);
        check("drop_to_rtz", d, n, RSP);
        ao[d] = 1'b0;
        wait_sig(d, 3, 1'b0, n);
        check("ao_low_to_idle", d, n, RSP);
        check("gnt_idle", d, {30'd0, gnt[d]}, 32'd0);
        check("acks_idle", d, {30'd0, a1[d], a0[d]}, 32'd0);
        mprio[d] = ~mprio[d];
    endtask

    // Both channels raise together; the loser is served from the next IDLE.
    task automatic contend(input int d, input int lit_first);
        int w;
        r0[d] = 1'b1;
        r1[d] = 1'b1;
        w = winner(d, 1'b1, 1'b1);
        check("model_first", d, w, lit_first);
        serve(d, w, RSP);
        serve(d, 1 - w, 1);
    endtask

    // Per-cycle invariants plus the model's grant.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check("both_acks", d, {31'd0, a0[d] & a1[d]}, 32'd0);
                check("busy_vs_gnt", d, {31'd0, busy[d]}, {31'd0, gnt[d] != 2'b00});
                if (gnt[d] != 2'b00)
                    check("gnt_model", d, {30'd0, gnt[d]}, {30'd0, exp_gnt[d]});
                check("a0_owner", d, {31'd0, a0[d] & ~gnt[d][0]}, 32'd0);
                check("a1_owner", d, {31'd0, a1[d] & ~gnt[d][1]}, 32'd0);
                check("ro_busy", d, {31'd0, ro[d] & ~busy[d]}, 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            r0[d] = 1'b0; r1[d] = 1'b0; ao[d] = 1'b0;
            mprio[d] = 1'b0; exp_gnt[d] = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ro", d, {31'd0, ro[d]}, 32'd0);
            check("rst_a0", d, {31'd0, a0[d]}, 32'd0);
            check("rst_a1", d, {31'd0, a1[d]}, 32'd0);
            check("rst_gnt", d, {30'd0, gnt[d]}, 32'd0);
            check("rst_busy", d, {31'd0, busy[d]}, 32'd0);
        end
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin: first contention after reset goes to channel 0.
        contend(0, 0);
        // Lone channel-0 transaction, exact latencies.
        r0[0] = 1'b1;
        w = winner(0, 1'b1, 1'b0);
        check("model_single", 0, w, 0);
        serve(0, w, RSP);
        // Priority now sits with channel 1.
        contend(0, 1);

        // Fixed priority: channel 0 wins every contention.
        contend(1, 0);
        contend(1, 0);
        r1[1] = 1'b1;
        serve(1, 1, RSP);
        contend(1, 0);

        // Premature drop of the granted request while forwarding.
        r0[0] = 1'b1;
        exp_gnt[0] = 2'b01;
        wait_sig(0, 0, 1'b1, n);
        check("pre_req_to_ro", 0, n, RSP);
        r0[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_ro_held", 0, {31'd0, ro[0]}, 32'd1);
        check("pre_busy_held", 0, {31'd0, busy[0]}, 32'd1);
        ao[0] = 1'b1;
        wait_sig(0, 1, 1'b1, n);
        check("pre_ao_to_ack", 0, n, RSP);
        wait_sig(0, 0, 1'b0, n);
        check("pre_ack_to_rtz", 0, n, 1);
        ao[0] = 1'b0;
        wait_sig(0, 3, 1'b0, n);
        check("pre_idle", 0, n, RSP);
        mprio[0] = ~mprio[0];

        // Reset while in ACKD.
        r0[0] = 1'b1;
        exp_gnt[0] = 2'b01;
        wait_sig(0, 0, 1'b1, n);
        ao[0] = 1'b1;
        wait_sig(0, 1, 1'b1, n);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ro", 0, {31'd0, ro[0]}, 32'd0);
        check("mid_rst_a0", 0, {31'd0, a0[0]}, 32'd0);
        check("mid_rst_a1", 0, {31'd0, a1[0]}, 32'd0);
        check("mid_rst_gnt", 0, {30'd0, gnt[0]}, 32'd0);
        check("mid_rst_busy", 0, {31'd0, busy[0]}, 32'd0);
        rst = 1'b0;
        r0[0] = 1'b0;
        ao[0] = 1'b0;
        mprio[0] = 1'b0;
        mprio[1] = 1'b0;
        @(posedge clk);
        #1;
        r1[0] = 1'b1;
        serve(0, 1, RSP);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
